// File: rtl/memaccess_pkg.sv
// Shared definitions for the RV32I memory-access stage.
// Holds funct3 width codes, FSM state encoding, bus/pipeline payload
// structs and the store lane-placement helpers.
package memaccess_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OFF_W = 2;

  // funct3 load/store width codes
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // Access size = funct3[1:0]; the sign bit funct3[2] only matters for loads
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Request fields presented on the data-memory bus
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } dmem_bus_t;

  // Memory instruction captured while its bus transfer is outstanding
  typedef struct packed {
    logic             regwrite;
    logic             memtoreg;
    logic             load;
    logic [F3_W-1:0]  f3;
    logic [OFF_W-1:0] off;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  alu;
  } mem_pend_t;

  // Memory -> writeback pipeline register
  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memtoreg;
    logic             misalign;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  rdata;
  } wb_t;

  // Byte enables for a store of the given size at byte offset off
  function automatic logic [BE_W-1:0] store_be(input logic [1:0] sz,
                                               input logic [OFF_W-1:0] off);
    logic [BE_W-1:0] be;
    be = '1;
    case (sz)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = '1;
    endcase
    return be;
  endfunction

  // Replicate store data so every lane carries the value
  function automatic logic [XLEN-1:0] store_wdata(input logic [1:0] sz,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    w = d;
    case (sz)
      SZ_B:    w = {4{d[7:0]}};
      SZ_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/memaccess_load_align.sv
// Load alignment: selects the byte/half addressed by the word offset and
// sign- or zero-extends it according to funct3. Purely combinational.
// Ports:
//   strctrl_i    funct3 width code
//   off_i        byte offset within the word
//   rdata_i      word returned by memory
//   ext_data_c_o aligned, extended load value (combinational)
module memaccess_load_align
  import memaccess_pkg::*;
(
  input  logic [F3_W-1:0]  strctrl_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [XLEN-1:0]  ext_data_c_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select; halves are picked by off[1] only
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extension by width code
  always_comb begin
    ext_data_c_o = rdata_i;
    case (strctrl_i)
      F3_LB:   ext_data_c_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ext_data_c_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  ext_data_c_o = {24'h0, byte_sel};
      F3_LHU:  ext_data_c_o = {16'h0, half_sel};
      F3_LW:   ext_data_c_o = rdata_i;
      default: ext_data_c_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memaccess.sv
// Memory-access stage of the five-stage RV32I pipeline.
// Issues loads/stores on a single-port req/ack data bus, stalls upstream
// while a transfer is outstanding, and registers results into writeback.
// Optional feature macro: MEMACC_MISALIGN_TRAP_EN -- misaligned H/W
// accesses are not sent to the bus and are flagged on misalignW instead.
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   validM, RegWriteM,
//   MemWriteM, MemtoRegM       execute->memory controls
//   strCtrlM                   funct3 width code
//   ALUoutM, r2M, rdM          address/ALU result, store data, dest reg
//   stallM                     combinational hold for upstream stages
//   dmem_req/we/addr/be/wdata  data-memory request
//   dmem_ack, dmem_rdata       data-memory response
//   validW, RegWriteW,
//   MemtoRegW, rdW, ALUoutW,
//   ReadDataW, misalignW       writeback pipeline register
module memaccess
  import memaccess_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             validM,
  input  logic             RegWriteM,
  input  logic             MemWriteM,
  input  logic             MemtoRegM,
  input  logic [F3_W-1:0]  strCtrlM,
  input  logic [XLEN-1:0]  ALUoutM,
  input  logic [XLEN-1:0]  r2M,
  input  logic [REG_W-1:0] rdM,
  output logic             stallM,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [BE_W-1:0]  dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             validW,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic [REG_W-1:0] rdW,
  output logic [XLEN-1:0]  ALUoutW,
  output logic [XLEN-1:0]  ReadDataW,
  output logic             misalignW
);

  state_e     state_q, state_d;
  logic       req_q, req_d;
  dmem_bus_t  bus_q, bus_d;
  mem_pend_t  pend_q, pend_d;
  wb_t        wb_q, wb_d;

  logic             memop_c;
  logic             misal_c;
  logic             acc_go_c;
  logic [OFF_W-1:0] off_c;
  logic [XLEN-1:0]  load_ext_c;

  assign memop_c = validM & (MemWriteM | MemtoRegM);
  assign off_c   = ALUoutM[OFF_W-1:0];

`ifdef MEMACC_MISALIGN_TRAP_EN
  // Halfword needs off[0]=0, word needs off=00
  assign misal_c = memop_c &
                   (((strCtrlM[1:0] == SZ_H) & off_c[0]) |
                    ((strCtrlM[1:0] == SZ_W) & (off_c != 2'b00)));
`else
  assign misal_c = 1'b0;
`endif

  // A trapped access behaves like a non-memory op: no bus, no stall
  assign acc_go_c = memop_c & ~misal_c;

  // Released in the ack cycle so the next instruction can enter M at that edge
  assign stallM = ((state_q == ST_IDLE) & acc_go_c) |
                  ((state_q == ST_WAIT) & ~dmem_ack);

  memaccess_load_align u_load_align (
    .strctrl_i    (pend_q.f3),
    .off_i        (pend_q.off),
    .rdata_i      (dmem_rdata),
    .ext_data_c_o (load_ext_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    bus_d   = bus_q;
    pend_d  = pend_q;
    wb_d    = wb_q;

    case (state_q)
      ST_IDLE: begin
        if (acc_go_c) begin
          state_d     = ST_WAIT;
          req_d       = 1'b1;
          bus_d.we    = MemWriteM;
          bus_d.addr  = {ALUoutM[XLEN-1:OFF_W], 2'b00};
          bus_d.be    = MemWriteM ? store_be(strCtrlM[1:0], off_c) : '1;
          bus_d.wdata = MemWriteM ? store_wdata(strCtrlM[1:0], r2M) : '0;

          pend_d.regwrite = RegWriteM;
          pend_d.memtoreg = MemtoRegM;
          pend_d.load     = MemtoRegM & ~MemWriteM;
          pend_d.f3       = strCtrlM;
          pend_d.off      = off_c;
          pend_d.rd       = rdM;
          pend_d.alu      = ALUoutM;

          // Bubble into W while the transfer is outstanding
          wb_d.valid    = 1'b0;
          wb_d.regwrite = 1'b0;
          wb_d.memtoreg = 1'b0;
          wb_d.misalign = 1'b0;
        end else begin
          wb_d.valid    = validM;
          wb_d.regwrite = validM & RegWriteM & ~misal_c;
          wb_d.memtoreg = validM & MemtoRegM & ~misal_c;
          wb_d.misalign = misal_c;
          wb_d.rd       = rdM;
          wb_d.alu      = ALUoutM;
        end
      end

      ST_WAIT: begin
        if (dmem_ack) begin
          state_d       = ST_IDLE;
          req_d         = 1'b0;
          wb_d.valid    = 1'b1;
          wb_d.regwrite = pend_q.regwrite;
          wb_d.memtoreg = pend_q.memtoreg;
          wb_d.misalign = 1'b0;
          wb_d.rd       = pend_q.rd;
          wb_d.alu      = pend_q.alu;
          if (pend_q.load) begin
            wb_d.rdata = load_ext_c;
          end
        end else begin
          wb_d.valid    = 1'b0;
          wb_d.regwrite = 1'b0;
          wb_d.memtoreg = 1'b0;
          wb_d.misalign = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      bus_q   <= '0;
      pend_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      bus_q   <= bus_d;
      pend_q  <= pend_d;
      wb_q    <= wb_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = bus_q.we;
  assign dmem_addr  = bus_q.addr;
  assign dmem_be    = bus_q.be;
  assign dmem_wdata = bus_q.wdata;

  assign validW     = wb_q.valid;
  assign RegWriteW  = wb_q.regwrite;
  assign MemtoRegW  = wb_q.memtoreg;
  assign rdW        = wb_q.rd;
  assign ALUoutW    = wb_q.alu;
  assign ReadDataW  = wb_q.rdata;
  assign misalignW  = wb_q.misalign;

endmodule

// File: tb/tb_memaccess.sv
// Testbench for memaccess: directed vector table, hand-written reset and
// misalignment sequences, then random instructions checked against a
// transaction-level reference model.
module tb_memaccess;

  logic        clk = 1'b0;
  logic        rst;
  logic        validM, RegWriteM, MemWriteM, MemtoRegM;
  logic [2:0]  strCtrlM;
  logic [31:0] ALUoutM, r2M;
  logic [4:0]  rdM;
  logic        stallM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        validW, RegWriteW, MemtoRegW;
  logic [4:0]  rdW;
  logic [31:0] ALUoutW, ReadDataW;
  logic        misalignW;

  int n_tests = 0;
  int n_fail  = 0;

  memaccess dut (
    .clk(clk), .rst(rst),
    .validM(validM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .MemtoRegM(MemtoRegM), .strCtrlM(strCtrlM), .ALUoutM(ALUoutM),
    .r2M(r2M), .rdM(rdM), .stallM(stallM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .validW(validW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .rdW(rdW), .ALUoutW(ALUoutW), .ReadDataW(ReadDataW),
    .misalignW(misalignW)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        v, mw, mr, rw;
    logic [2:0]  f3;
    logic [31:0] a, r2;
    logic [4:0]  rd;
    int          dly;
    logic [31:0] word;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, mw, mr, rw, input logic [2:0] f3,
                              input logic [31:0] a, r2, input logic [4:0] rd,
                              input int dly, input logic [31:0] word, e_addr,
                              input logic [3:0] e_be, input logic [31:0] e_wdata, e_rdata);
    vec_t t;
    t.v = v; t.mw = mw; t.mr = mr; t.rw = rw; t.f3 = f3; t.a = a; t.r2 = r2;
    t.rd = rd; t.dly = dly; t.word = word; t.e_addr = e_addr; t.e_be = e_be;
    t.e_wdata = e_wdata; t.e_rdata = e_rdata;
    return t;
  endfunction

  // ---------------- reference model (arithmetic on the stated rules) -------
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a, input logic st);
    int unsigned off;
    off = a % 4;
    if (!st) return 4'hF;
    if (f3 % 4 == 0) return 4'((1 << off));
    if (f3 % 4 == 1) return 4'((3 << ((off / 2) * 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 % 4 == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 % 4 == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> ((a % 4) * 8)) & 32'hFF;
    h = (w >> (((a % 4) / 2) * 16)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a, input logic memop);
`ifdef MEMACC_MISALIGN_TRAP_EN
    return memop && (((f3 % 4 == 1) && (a % 2 != 0)) || ((f3 % 4 == 2) && (a % 4 != 0)));
`else
    return 1'b0 & memop & f3[0] & a[0];
`endif
  endfunction

  // Apply one instruction at M and follow it to W, checking every cycle
  task automatic run_op(input string tag, input vec_t t, input logic e_mis);
    logic is_mem;
    validM = t.v; MemWriteM = t.mw; MemtoRegM = t.mr; RegWriteM = t.rw;
    strCtrlM = t.f3; ALUoutM = t.a; r2M = t.r2; rdM = t.rd;
    is_mem = t.v && (t.mw || t.mr) && !e_mis;
    if (!is_mem) begin
      dmem_ack = 1'($urandom_range(0, 1));   // stray ack in IDLE must be ignored
      dmem_rdata = $urandom;
      #1 chk({tag, "_stall"}, stallM, 0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk({tag, "_req"}, dmem_req, 0);
      chk({tag, "_validW"}, validW, t.v);
      if (t.v) begin
        chk({tag, "_rdW"}, rdW, t.rd);
        chk({tag, "_ALUoutW"}, ALUoutW, t.a);
        chk({tag, "_RegWriteW"}, RegWriteW, e_mis ? 1'b0 : t.rw);
        chk({tag, "_misalignW"}, misalignW, e_mis);
      end
    end else begin
      dmem_ack = 1'b0;
      #1 chk({tag, "_stall0"}, stallM, 1);
      @(posedge clk); #1;
      for (int c = 1; c <= t.dly; c++) begin
        chk({tag, "_req"}, dmem_req, 1);
        chk({tag, "_we"}, dmem_we, t.mw);
        chk({tag, "_addr"}, dmem_addr, t.e_addr);
        chk({tag, "_be"}, dmem_be, t.e_be);
        if (t.mw) chk({tag, "_wdata"}, dmem_wdata, t.e_wdata);
        chk({tag, "_bubble"}, validW, 0);
        if (c == t.dly) begin
          dmem_ack = 1'b1; dmem_rdata = t.word;
          #1 chk({tag, "_stall_ack"}, stallM, 0);
        end else begin
          #1 chk({tag, "_stall_wait"}, stallM, 1);
        end
        @(posedge clk); #1;
      end
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      chk({tag, "_req_drop"}, dmem_req, 0);
      chk({tag, "_validW"}, validW, 1);
      chk({tag, "_RegWriteW"}, RegWriteW, t.rw);
      chk({tag, "_MemtoRegW"}, MemtoRegW, t.mr);
      chk({tag, "_rdW"}, rdW, t.rd);
      chk({tag, "_ALUoutW"}, ALUoutW, t.a);
      chk({tag, "_misalignW"}, misalignW, 0);
      if (t.mr && !t.mw) chk({tag, "_ReadDataW"}, ReadDataW, t.e_rdata);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stallM"}, stallM, 0);
    chk({tag, "_req"}, dmem_req, 0);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_be"}, dmem_be, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_validW"}, validW, 0);
    chk({tag, "_RegWriteW"}, RegWriteW, 0);
    chk({tag, "_MemtoRegW"}, MemtoRegW, 0);
    chk({tag, "_rdW"}, rdW, 0);
    chk({tag, "_ALUoutW"}, ALUoutW, 0);
    chk({tag, "_ReadDataW"}, ReadDataW, 0);
    chk({tag, "_misalignW"}, misalignW, 0);
  endtask

  vec_t vec [10];
  logic [2:0] ld_f3 [5];

  initial begin
    vec_t t;
    int   kind;

    //        v   mw  mr  rw  f3    addr          r2            rd  dly word          e_addr        e_be     e_wdata       e_rdata
    vec[0] = mk(1, 0, 0, 1, 3'd0, 32'h0000_0009, 32'h0,        5,  0, 32'h0,        32'h0,        4'h0,    32'h0,        32'h0);
    vec[1] = mk(1, 1, 0, 0, 3'd0, 32'h0000_0102, 32'h1234_56A7, 0, 2, 32'h0,        32'h0000_0100, 4'b0100, 32'hA7A7_A7A7, 32'h0);
    vec[2] = mk(1, 0, 1, 1, 3'd0, 32'h0000_0103, 32'h0,        7,  1, 32'h80FF_0000, 32'h0000_0100, 4'hF,    32'h0,        32'hFFFF_FF80);
    vec[3] = mk(1, 0, 1, 1, 3'd4, 32'h0000_0103, 32'h0,        8,  1, 32'h80FF_0000, 32'h0000_0100, 4'hF,    32'h0,        32'h0000_0080);
    vec[4] = mk(1, 0, 1, 1, 3'd5, 32'h0000_0102, 32'h0,        9,  2, 32'h80FF_0000, 32'h0000_0100, 4'hF,    32'h0,        32'h0000_80FF);
    vec[5] = mk(1, 0, 1, 1, 3'd2, 32'h0000_0200, 32'h0,        10, 5, 32'hDEAD_BEEF, 32'h0000_0200, 4'hF,    32'h0,        32'hDEAD_BEEF);
    vec[6] = mk(1, 1, 0, 0, 3'd1, 32'h0000_0206, 32'hCAFE_1234, 0, 1, 32'h0,        32'h0000_0204, 4'b1100, 32'h1234_1234, 32'h0);
    vec[7] = mk(1, 1, 0, 0, 3'd2, 32'h0000_0300, 32'h89AB_CDEF, 0, 3, 32'h0,        32'h0000_0300, 4'hF,    32'h89AB_CDEF, 32'h0);
    vec[8] = mk(1, 0, 1, 1, 3'd1, 32'h0000_0100, 32'h0,        11, 1, 32'h1234_8001, 32'h0000_0100, 4'hF,    32'h0,        32'hFFFF_8001);
    vec[9] = mk(0, 1, 0, 0, 3'd2, 32'h0000_0400, 32'h5555_AAAA, 0, 1, 32'h0,        32'h0,        4'h0,    32'h0,        32'h0);

    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

    rst = 1'b0;
    validM = 0; RegWriteM = 0; MemWriteM = 0; MemtoRegM = 0;
    strCtrlM = 0; ALUoutM = 0; r2M = 0; rdM = 0;
    dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), vec[i], 1'b0);

    // LW at 0x101: trapped with the feature, otherwise an aligned word access
    t = mk(1, 0, 1, 1, 3'd2, 32'h0000_0101, 32'h0, 12, 1, 32'h1122_3344,
           32'h0000_0100, 4'hF, 32'h0, 32'h1122_3344);
`ifdef MEMACC_MISALIGN_TRAP_EN
    run_op("lw_mis", t, 1'b1);
`else
    run_op("lw_mis", t, 1'b0);
`endif

    // Reset while waiting for ack, then a late ack
    validM = 1; MemtoRegM = 1; MemWriteM = 0; RegWriteM = 1;
    strCtrlM = 3'd2; ALUoutM = 32'h0000_0500; rdM = 5'd3;
    @(posedge clk); #1;
    chk("rstwait_req_up", dmem_req, 1);
    rst = 1'b0;
    validM = 0; MemtoRegM = 0; RegWriteM = 0; strCtrlM = 0; ALUoutM = 0; rdM = 0; r2M = 0;
    @(posedge clk); #1;
    chk_all_zero("rstwait");
    rst = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    #1 chk("late_ack_stall", stallM, 0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_validW", validW, 0);
    chk("late_ack_ReadDataW", ReadDataW, 0);

    // Random instruction stream against the reference model
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 2));
      t.v  = ($urandom_range(0, 9) != 0);
      t.a  = $urandom;
      t.r2 = $urandom;
      t.rd = 5'($urandom);
      t.dly = int'($urandom_range(1, 4));
      t.word = $urandom;
      if (kind == 0) begin
        t.mw = 0; t.mr = 0; t.rw = 1'($urandom); t.f3 = 3'($urandom);
      end else if (kind == 1) begin
        t.mw = 0; t.mr = 1; t.rw = 1; t.f3 = ld_f3[$urandom_range(0, 4)];
      end else begin
        t.mw = 1; t.mr = 0; t.rw = 0; t.f3 = 3'($urandom_range(0, 2));
      end
      t.e_addr  = t.a & 32'hFFFF_FFFC;
      t.e_be    = m_be(t.f3, t.a, t.mw);
      t.e_wdata = m_wdata(t.f3, t.r2);
      t.e_rdata = m_load(t.f3, t.a, t.word);
      run_op("rnd", t, m_mis(t.f3, t.a, t.v && (t.mw || t.mr)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
